fu_cdb_arb: RTL and testbench
=============================

// Module: fu_cdb_arb
// PURPOSE
//  Parametrised completion/writeback arbiter between the execution units and the CDB/PRF/ROB.
//  Each of NUM_CH units pushes results into a private FIFO.
//  One result per cycle is granted to the CDB, PRF write port and ROB done port.
//  Replaces the fixed-priority mux and ad-hoc stall signals of the current FU top.
//  Adds per-unit buffering, round-robin fairness and branch-mask squash of buffered results.
// PARAMETERS
//  NUM_CH     4   number of completion channels (>=2)
//  BUF_DEPTH  2   entries per channel FIFO (power of 2, >=2)
//  DATA_W     64  result value width
//  PRF_IDX_W  6   physical register tag width
//  ROB_IDX_W  5   ROB index width (ports carry ROB_IDX_W+1 bits, incl. wrap bit)
//  BR_MASK_W  5   branch mask width
//  PRIO_CH0   1   1: ch0 (branch unit) has fixed top priority; 0: ch0 joins round-robin
// PORTS
//  clk             in   1                   clock
//  rst             in   1                   asynchronous reset, active-high
//  ch_vld_i        in   NUM_CH              per-channel result valid
//  ch_rdy_o        out  NUM_CH              per-channel FIFO not full
//  ch_wr_en_i      in   NUM_CH              result writes a PRF register
//  ch_tag_i        in   NUM_CH*PRF_IDX_W    dest tags, packed, ch0 in LSBs
//  ch_value_i      in   NUM_CH*DATA_W       result values, packed
//  ch_rob_idx_i    in   NUM_CH*(ROB_IDX_W+1) ROB indices, packed
//  ch_br_mask_i    in   NUM_CH*BR_MASK_W    branch masks, packed
//  rob_br_recovery_i     in  1          mispredict recovery this cycle
//  rob_br_pred_correct_i in  1          branch resolved correct this cycle
//  rob_br_tag_fix_i      in  BR_MASK_W  one-hot branch tag being resolved
//  cdb_vld_o       out  1                   CDB broadcast + PRF write enable
//  cdb_tag_o       out  PRF_IDX_W           broadcast/write tag
//  cdb_value_o     out  DATA_W              PRF write value
//  rob_done_o      out  1                   ROB completion strobe
//  rob_idx_o       out  ROB_IDX_W+1         ROB index completing
//  grant_o         out  NUM_CH              one-hot channel granted this cycle
// BEHAVIOUR
//  Reset:
//   - All FIFOs empty, RR pointer = ch0 (ch1 when PRIO_CH0=1).
//   - All outputs 0; ch_rdy_o all 1 once rst falls.
//  Push:
//   - ch_vld_i & ch_rdy_o writes one entry {wr_en,tag,value,rob_idx,br_mask,live=1} at tail.
//   - ch_rdy_o = ~full from registered counts only; a full FIFO refuses push even if popping.
//   - ch_vld_i while ~ch_rdy_o is a producer error; the data is dropped (bench asserts).
//  Latency:
//   - Entry pushed at edge t is eligible at cycle t+1.
//   - No input->output combinational path.
//  Arbitration (combinational from FIFO heads, registered state):
//   - Eligible = head exists, live, and not killed this cycle.
//   - PRIO_CH0=1 and ch0 eligible -> grant ch0.
//   - Else round-robin: first eligible channel at or after RR pointer, wrapping.
//   - RR pointer moves to (granted+1) mod NUM_CH, skipping ch0 when PRIO_CH0=1.
//   - RR pointer does not move when ch0 is granted by fixed priority or there is no grant.
//  Output:
//   - On grant: rob_done_o=1, rob_idx_o=head rob_idx, cdb_vld_o=head wr_en.
//   - cdb_tag_o/cdb_value_o = head values when wr_en, else 0.
//   - No grant: all outputs 0. Granted head pops.
//  Dead heads:
//   - A head with live=0 pops automatically in the same cycle.
//   - Consumes no grant; at most one dead pop per channel per cycle.
//  Branch resolve, applied to stored entries and same-cycle pushes:
//   - pred_correct: clear bit rob_br_tag_fix_i in every br_mask.
//   - recovery: entries with (br_mask & tag_fix)!=0 get live=0 and cannot be granted this cycle.
//   - recovery: matching pushes are written with live=0.
//   - recovery & pred_correct together: recovery wins.
//   - cdb_vld_o/rob_done_o additionally gated with ~rob_br_recovery_i.
//  Pointers: head/tail use DEPTH_W+1 bits (wrap bit); full = MSB differ, rest equal.
//  Simultaneous push+pop on a non-full FIFO: count unchanged, both pointers advance.
//  Async reset mid-operation: all buffered results discarded, outputs 0 immediately.
// TESTING
//  1. Reset, push ch2 {wr_en=1,tag=9,val=0xDEAD,rob=3} at t0 -> t1: cdb_vld=1, tag=9, rob_idx=3, grant=0100.
//  2. PRIO_CH0=0, ch0..3 push together for 4 cycles:
//     -> grants 0001,0010,0100,1000 repeat; no channel starved.
//  3. PRIO_CH0=1, ch0 pushes every cycle, ch1 holds one entry:
//     -> ch0 always granted; ch1 ch_rdy stays 1 until FIFO full (2 pushes), then 0.
//  4. ch1 holds mask 00010 entry, recovery with tag_fix=00010:
//     -> entry never granted; ch1 empty next cycle; ch1 mask-00000 entry behind it still granted.
//  5. pred_correct tag_fix=00100 on buffered mask 00110, then recovery tag_fix=00100:
//     -> entry survives and is granted.
//  6. ch3 push with wr_en=0, rob=17 -> rob_done=1, rob_idx=17, cdb_vld=0, tag=0; assert rst mid-stream -> outputs 0, FIFOs empty.

Source files
------------

// File: rtl/fu_cdb_arb_if.sv
// Completion-arbiter bundle: execution-unit result channels, branch-resolve
// broadcast from the ROB, and the single granted writeback toward CDB/PRF/ROB.
interface fu_cdb_arb_if #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 64,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 5
);
  logic [NUM_CH-1:0]                 ch_vld;
  logic [NUM_CH-1:0]                 ch_rdy;
  logic [NUM_CH-1:0]                 ch_wr_en;
  logic [NUM_CH*PRF_IDX_W-1:0]       ch_tag;
  logic [NUM_CH*DATA_W-1:0]          ch_value;
  logic [NUM_CH*(ROB_IDX_W+1)-1:0]   ch_rob_idx;
  logic [NUM_CH*BR_MASK_W-1:0]       ch_br_mask;
  logic                              rob_br_recovery;
  logic                              rob_br_pred_correct;
  logic [BR_MASK_W-1:0]              rob_br_tag_fix;
  logic                              cdb_vld;
  logic [PRF_IDX_W-1:0]              cdb_tag;
  logic [DATA_W-1:0]                 cdb_value;
  logic                              rob_done;
  logic [ROB_IDX_W:0]                rob_idx;
  logic [NUM_CH-1:0]                 grant;

  modport master (
    output ch_vld, ch_wr_en, ch_tag, ch_value, ch_rob_idx, ch_br_mask,
    output rob_br_recovery, rob_br_pred_correct, rob_br_tag_fix,
    input  ch_rdy, cdb_vld, cdb_tag, cdb_value, rob_done, rob_idx, grant
  );

  modport slave (
    input  ch_vld, ch_wr_en, ch_tag, ch_value, ch_rob_idx, ch_br_mask,
    input  rob_br_recovery, rob_br_pred_correct, rob_br_tag_fix,
    output ch_rdy, cdb_vld, cdb_tag, cdb_value, rob_done, rob_idx, grant
  );
endinterface

// File: rtl/fu_cdb_arb.sv
// Writeback arbiter: per-unit result FIFOs with branch-mask squash, one grant per
// cycle to CDB/PRF/ROB, optional fixed priority for ch0 and round-robin otherwise.
module fu_cdb_arb #(
  parameter int NUM_CH    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = 64,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 5,
  parameter int PRIO_CH0  = 1
) (
  input logic         clk,
  input logic         rst,
  fu_cdb_arb_if.slave bus
);
  localparam int DEPTH_W = $clog2(BUF_DEPTH);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int ROB_W   = ROB_IDX_W + 1;
  localparam logic [CH_W-1:0] RR_INIT  = (PRIO_CH0 != 0) ? CH_W'(1) : '0;
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [NUM_CH-1:0]    full, empty, eligible, dead_pop, pop, push;
  logic [NUM_CH-1:0]    head_wr_en;
  logic [PRF_IDX_W-1:0] head_tag   [NUM_CH];
  logic [DATA_W-1:0]    head_value [NUM_CH];
  logic [ROB_W-1:0]     head_rob   [NUM_CH];

  logic [NUM_CH-1:0]    grant;
  logic                 grant_any;
  logic [CH_W-1:0]      grant_idx;
  logic [CH_W-1:0]      rr_reg, rr_next;
  logic [CH_W:0]        cand, nxt;
  logic                 cdb_vld;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DEPTH_W:0]     head_reg, tail_reg;
      logic [DEPTH_W-1:0]   head_addr, tail_addr;
      logic                 wr_en_mem [BUF_DEPTH];
      logic [PRF_IDX_W-1:0] tag_mem   [BUF_DEPTH];
      logic [DATA_W-1:0]    value_mem [BUF_DEPTH];
      logic [ROB_W-1:0]     rob_mem   [BUF_DEPTH];
      logic [BR_MASK_W-1:0] mask_reg  [BUF_DEPTH];
      logic                 live_reg  [BUF_DEPTH];
      logic [BR_MASK_W-1:0] in_mask, push_mask;
      logic                 push_live, killed;

      assign head_addr = head_reg[DEPTH_W-1:0];
      assign tail_addr = tail_reg[DEPTH_W-1:0];
      assign full[gi]  = (head_reg[DEPTH_W] != tail_reg[DEPTH_W]) &&
                         (head_reg[DEPTH_W-1:0] == tail_reg[DEPTH_W-1:0]);
      assign empty[gi] = (head_reg == tail_reg);

      // A head squashed by this cycle's recovery is treated exactly like a dead head.
      assign killed       = bus.rob_br_recovery && |(mask_reg[head_addr] & bus.rob_br_tag_fix);
      assign eligible[gi] = ~empty[gi] & live_reg[head_addr] & ~killed;
      assign dead_pop[gi] = ~empty[gi] & ~eligible[gi];
      assign pop[gi]      = dead_pop[gi] | grant[gi];
      assign push[gi]     = bus.ch_vld[gi] & ~full[gi];
      assign bus.ch_rdy[gi] = ~full[gi] & ~rst;

      assign in_mask   = bus.ch_br_mask[gi*BR_MASK_W +: BR_MASK_W];
      assign push_live = ~(bus.rob_br_recovery && |(in_mask & bus.rob_br_tag_fix));
      assign push_mask = (bus.rob_br_pred_correct && !bus.rob_br_recovery) ?
                         (in_mask & ~bus.rob_br_tag_fix) : in_mask;

      assign head_wr_en[gi] = wr_en_mem[head_addr];
      assign head_tag[gi]   = tag_mem[head_addr];
      assign head_value[gi] = value_mem[head_addr];
      assign head_rob[gi]   = rob_mem[head_addr];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_reg <= '0;
          tail_reg <= '0;
        end else begin
          if (pop[gi])  head_reg <= head_reg + 1'b1;
          if (push[gi]) tail_reg <= tail_reg + 1'b1;
        end
      end

      // Payload needs no reset: occupancy is tracked entirely by the pointers.
      always_ff @(posedge clk) begin
        for (int e = 0; e < BUF_DEPTH; e++) begin
          if (bus.rob_br_recovery && |(mask_reg[e] & bus.rob_br_tag_fix))
            live_reg[e] <= 1'b0;
          else if (bus.rob_br_pred_correct)
            mask_reg[e] <= mask_reg[e] & ~bus.rob_br_tag_fix;
        end
        if (push[gi]) begin
          wr_en_mem[tail_addr] <= bus.ch_wr_en[gi];
          tag_mem[tail_addr]   <= bus.ch_tag[gi*PRF_IDX_W +: PRF_IDX_W];
          value_mem[tail_addr] <= bus.ch_value[gi*DATA_W +: DATA_W];
          rob_mem[tail_addr]   <= bus.ch_rob_idx[gi*ROB_W +: ROB_W];
          mask_reg[tail_addr]  <= push_mask;
          live_reg[tail_addr]  <= push_live;
        end
      end
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!bus.rob_br_recovery) begin
      if (PRIO_CH0 != 0 && eligible[0]) begin
        grant_any = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          cand = {1'b0, rr_reg} + (CH_W+1)'(k);
          if (cand >= NUM_CH_L) cand = cand - NUM_CH_L;
          if (!grant_any && eligible[cand[CH_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[CH_W-1:0];
          end
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  // Fixed-priority ch0 grants leave the rotation untouched.
  always_comb begin
    rr_next = rr_reg;
    nxt     = '0;
    if (grant_any && !(PRIO_CH0 != 0 && grant_idx == '0)) begin
      nxt = {1'b0, grant_idx} + 1'b1;
      if (nxt >= NUM_CH_L) nxt = '0;
      if (PRIO_CH0 != 0 && nxt == '0) nxt = (CH_W+1)'(1);
      rr_next = nxt[CH_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_reg <= RR_INIT;
    else     rr_reg <= rr_next;
  end

  assign cdb_vld       = grant_any & head_wr_en[grant_idx];
  assign bus.grant     = grant;
  assign bus.rob_done  = grant_any;
  assign bus.rob_idx   = grant_any ? head_rob[grant_idx] : '0;
  assign bus.cdb_vld   = cdb_vld;
  assign bus.cdb_tag   = cdb_vld ? head_tag[grant_idx] : '0;
  assign bus.cdb_value = cdb_vld ? head_value[grant_idx] : '0;
endmodule

// File: tb/tb_fu_cdb_arb.sv
// Drives two arbiters (round-robin-only and ch0-priority) with the same stimulus and
// scores both against a queue-level behavioural model of the completion buffers.
module tb_fu_cdb_arb;
  localparam int NUM_CH = 4, BUF_DEPTH = 2, DATA_W = 64, PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5, BR_MASK_W = 5, ROB_W = ROB_IDX_W + 1;

  typedef struct {
    logic                 wr_en;
    logic [PRF_IDX_W-1:0] tag;
    logic [DATA_W-1:0]    value;
    logic [ROB_W-1:0]     rob;
    logic [BR_MASK_W-1:0] mask;
    logic                 live;
  } ent_t;

  typedef struct {
    logic [NUM_CH-1:0]    grant;
    logic [ROB_W-1:0]     rob;
    logic                 cdb_vld;
    logic [PRF_IDX_W-1:0] tag;
    logic [DATA_W-1:0]    value;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]               vld = '0, wr_en = '0;
  logic [NUM_CH*PRF_IDX_W-1:0]     tag_v = '0;
  logic [NUM_CH*DATA_W-1:0]        val_v = '0;
  logic [NUM_CH*ROB_W-1:0]         rob_v = '0;
  logic [NUM_CH*BR_MASK_W-1:0]     mask_v = '0;
  logic                            rec = 1'b0, pc = 1'b0;
  logic [BR_MASK_W-1:0]            fix = '0;

  fu_cdb_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PRF_IDX_W(PRF_IDX_W),
                  .ROB_IDX_W(ROB_IDX_W), .BR_MASK_W(BR_MASK_W)) bus0 ();
  fu_cdb_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PRF_IDX_W(PRF_IDX_W),
                  .ROB_IDX_W(ROB_IDX_W), .BR_MASK_W(BR_MASK_W)) bus1 ();

  assign bus0.ch_vld = vld;   assign bus1.ch_vld = vld;
  assign bus0.ch_wr_en = wr_en; assign bus1.ch_wr_en = wr_en;
  assign bus0.ch_tag = tag_v; assign bus1.ch_tag = tag_v;
  assign bus0.ch_value = val_v; assign bus1.ch_value = val_v;
  assign bus0.ch_rob_idx = rob_v; assign bus1.ch_rob_idx = rob_v;
  assign bus0.ch_br_mask = mask_v; assign bus1.ch_br_mask = mask_v;
  assign bus0.rob_br_recovery = rec; assign bus1.rob_br_recovery = rec;
  assign bus0.rob_br_pred_correct = pc; assign bus1.rob_br_pred_correct = pc;
  assign bus0.rob_br_tag_fix = fix; assign bus1.rob_br_tag_fix = fix;

  fu_cdb_arb #(.NUM_CH(NUM_CH), .BUF_DEPTH(BUF_DEPTH), .DATA_W(DATA_W), .PRF_IDX_W(PRF_IDX_W),
               .ROB_IDX_W(ROB_IDX_W), .BR_MASK_W(BR_MASK_W), .PRIO_CH0(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fu_cdb_arb #(.NUM_CH(NUM_CH), .BUF_DEPTH(BUF_DEPTH), .DATA_W(DATA_W), .PRF_IDX_W(PRF_IDX_W),
               .ROB_IDX_W(ROB_IDX_W), .BR_MASK_W(BR_MASK_W), .PRIO_CH0(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic                 o_done [2], o_cvld [2];
  logic [ROB_W-1:0]     o_rob  [2];
  logic [PRF_IDX_W-1:0] o_tag  [2];
  logic [DATA_W-1:0]    o_val  [2];
  logic [NUM_CH-1:0]    o_grant [2], o_rdy [2];
  assign o_done[0] = bus0.rob_done;  assign o_done[1] = bus1.rob_done;
  assign o_cvld[0] = bus0.cdb_vld;   assign o_cvld[1] = bus1.cdb_vld;
  assign o_rob[0]  = bus0.rob_idx;   assign o_rob[1]  = bus1.rob_idx;
  assign o_tag[0]  = bus0.cdb_tag;   assign o_tag[1]  = bus1.cdb_tag;
  assign o_val[0]  = bus0.cdb_value; assign o_val[1]  = bus1.cdb_value;
  assign o_grant[0] = bus0.grant;    assign o_grant[1] = bus1.grant;
  assign o_rdy[0]  = bus0.ch_rdy;    assign o_rdy[1]  = bus1.ch_rdy;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Behavioural model: each channel is an ordered list (index 0 = oldest) with a count.
  ent_t fifo [2][NUM_CH][BUF_DEPTH];
  int   cnt  [2][NUM_CH];
  int   rr   [2];
  out_t exp_q0 [$];
  out_t exp_q1 [$];

  task automatic model_step(input int d);
    int pre_cnt [NUM_CH];
    logic [NUM_CH-1:0] elig;
    int g;
    out_t o;
    ent_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      pre_cnt[c] = cnt[d][c];
      chk($sformatf("rdy dut%0d ch%0d", d, c), 64'(o_rdy[d][c]), 64'(cnt[d][c] < BUF_DEPTH));
      if (rec)
        for (int i = 0; i < cnt[d][c]; i++)
          if ((fifo[d][c][i].mask & fix) != '0) fifo[d][c][i].live = 1'b0;
      elig[c] = (cnt[d][c] > 0) && fifo[d][c][0].live;
    end
    g = -1;
    if (!rec) begin
      if (d == 1 && elig[0]) g = 0;
      else
        for (int k = 0; k < NUM_CH; k++)
          if (g < 0 && elig[(rr[d] + k) % NUM_CH]) g = (rr[d] + k) % NUM_CH;
    end
    if (g >= 0) begin
      e = fifo[d][g][0];
      o.grant = '0;
      o.grant[g] = 1'b1;
      o.rob = e.rob;
      o.cdb_vld = e.wr_en;
      o.tag = e.wr_en ? e.tag : '0;
      o.value = e.wr_en ? e.value : '0;
      if (d == 0) exp_q0.push_back(o); else exp_q1.push_back(o);
      if (!(d == 1 && g == 0)) begin
        rr[d] = (g + 1) % NUM_CH;
        if (d == 1 && rr[d] == 0) rr[d] = 1;
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      if (cnt[d][c] > 0 && (c == g || !fifo[d][c][0].live)) begin
        for (int i = 0; i < cnt[d][c] - 1; i++) fifo[d][c][i] = fifo[d][c][i+1];
        cnt[d][c]--;
      end
    if (pc && !rec)
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < cnt[d][c]; i++) fifo[d][c][i].mask = fifo[d][c][i].mask & ~fix;
    for (int c = 0; c < NUM_CH; c++)
      if (vld[c] && pre_cnt[c] < BUF_DEPTH) begin
        e.wr_en = wr_en[c];
        e.tag   = tag_v[c*PRF_IDX_W +: PRF_IDX_W];
        e.value = val_v[c*DATA_W +: DATA_W];
        e.rob   = rob_v[c*ROB_W +: ROB_W];
        e.mask  = mask_v[c*BR_MASK_W +: BR_MASK_W];
        e.live  = 1'b1;
        if (rec) begin
          if ((e.mask & fix) != '0) e.live = 1'b0;
        end else if (pc) e.mask = e.mask & ~fix;
        fifo[d][c][cnt[d][c]] = e;
        cnt[d][c]++;
      end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rdy_in_reset dut%0d", d), 64'(o_rdy[d]), 64'(0));
        for (int c = 0; c < NUM_CH; c++) cnt[d][c] = 0;
      end
      rr[0] = 0;
      rr[1] = 1;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic monitor_one(input int d);
    out_t o;
    logic have;
    have = 1'b0;
    if (d == 0 && exp_q0.size() > 0) begin o = exp_q0.pop_front(); have = 1'b1; end
    if (d == 1 && exp_q1.size() > 0) begin o = exp_q1.pop_front(); have = 1'b1; end
    if (o_done[d]) begin
      $display("txn dut%0d grant=%b rob_idx=%0d cdb_vld=%0b tag=%0d value=%0h",
               d, o_grant[d], o_rob[d], o_cvld[d], o_tag[d], o_val[d]);
      chk($sformatf("unexpected_grant dut%0d", d), 64'(have), 64'(1));
      if (have) begin
        chk($sformatf("grant dut%0d", d), 64'(o_grant[d]), 64'(o.grant));
        chk($sformatf("rob_idx dut%0d", d), 64'(o_rob[d]), 64'(o.rob));
        chk($sformatf("cdb_vld dut%0d", d), 64'(o_cvld[d]), 64'(o.cdb_vld));
        chk($sformatf("cdb_tag dut%0d", d), 64'(o_tag[d]), 64'(o.tag));
        chk($sformatf("cdb_value dut%0d", d), o_val[d], o.value);
      end
    end else begin
      chk($sformatf("missing_grant dut%0d", d), 64'(have), 64'(0));
      chk($sformatf("idle_outputs dut%0d", d),
          64'(o_cvld[d]) | 64'(o_tag[d]) | o_val[d] | 64'(o_rob[d]) | 64'(o_grant[d]), 64'(0));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      monitor_one(0);
      monitor_one(1);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    vld = '0;
    rec = 1'b0;
    pc  = 1'b0;
    fix = '0;
  endtask

  task automatic push(input int c, input logic we, input logic [PRF_IDX_W-1:0] t,
                      input logic [DATA_W-1:0] v, input logic [ROB_W-1:0] r,
                      input logic [BR_MASK_W-1:0] m);
    if (o_rdy[0][c] && o_rdy[1][c]) begin
      vld[c] = 1'b1;
      wr_en[c] = we;
      tag_v[c*PRF_IDX_W +: PRF_IDX_W] = t;
      val_v[c*DATA_W +: DATA_W] = v;
      rob_v[c*ROB_W +: ROB_W] = r;
      mask_v[c*BR_MASK_W +: BR_MASK_W] = m;
    end
  endtask

  task automatic push_rand(input int c, input logic [BR_MASK_W-1:0] m);
    push(c, 1'($urandom_range(0, 1)), PRF_IDX_W'($urandom), {$urandom, $urandom},
         ROB_W'($urandom), m);
  endtask

  function automatic logic [BR_MASK_W-1:0] sparse_mask();
    return BR_MASK_W'($urandom) & BR_MASK_W'($urandom);
  endfunction

  task automatic drain();
    repeat (12) next_cycle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single result appears the cycle after its push.
    next_cycle();
    push(2, 1'b1, 6'd9, 64'hDEAD, 6'd3, '0);
    next_cycle();
    #1;
    chk("t1_grant dut0", 64'(o_grant[0]), 64'h4);
    chk("t1_grant dut1", 64'(o_grant[1]), 64'h4);
    chk("t1_tag dut1", 64'(o_tag[1]), 64'd9);
    chk("t1_rob dut1", 64'(o_rob[1]), 64'd3);
    drain();

    // All channels contending.
    repeat (4) begin
      next_cycle();
      for (int c = 0; c < NUM_CH; c++) push_rand(c, '0);
    end
    drain();

    // ch0 streaming against a waiting ch1.
    next_cycle();
    push_rand(0, '0);
    push_rand(1, '0);
    repeat (5) begin
      next_cycle();
      push_rand(0, '0);
      push_rand(1, '0);
    end
    drain();

    // Recovery squashes a buffered entry; the one behind it survives.
    next_cycle();
    push_rand(1, 5'b00010);
    next_cycle();
    rec = 1'b1;
    fix = 5'b00010;
    push_rand(1, 5'b00000);
    drain();

    // Resolved-correct bit is cleared before a later recovery on the same tag.
    next_cycle();
    push_rand(2, 5'b00110);
    push_rand(0, '0);
    push_rand(1, '0);
    push_rand(3, '0);
    next_cycle();
    pc = 1'b1;
    fix = 5'b00100;
    next_cycle();
    rec = 1'b1;
    fix = 5'b00100;
    drain();

    // Non-writing result: ROB completion without CDB broadcast.
    next_cycle();
    push(3, 1'b0, 6'd5, 64'h1234, 6'd17, '0);
    next_cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t6_done dut%0d", d), 64'(o_done[d]), 64'd1);
      chk($sformatf("t6_rob dut%0d", d), 64'(o_rob[d]), 64'd17);
      chk($sformatf("t6_cdb_vld dut%0d", d), 64'(o_cvld[d]), 64'd0);
      chk($sformatf("t6_tag dut%0d", d), 64'(o_tag[d]), 64'd0);
    end
    repeat (4) begin
      next_cycle();
      for (int c = 0; c < NUM_CH; c++) push_rand(c, '0);
    end
    // Reset asserted mid-cycle with results buffered.
    next_cycle();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_done dut%0d", d), 64'(o_done[d]), 64'd0);
      chk($sformatf("rst_cdb_vld dut%0d", d), 64'(o_cvld[d]), 64'd0);
      chk($sformatf("rst_grant dut%0d", d), 64'(o_grant[d]), 64'd0);
      chk($sformatf("rst_rdy dut%0d", d), 64'(o_rdy[d]), 64'd0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    drain();

    // Randomised traffic with interleaved branch resolution.
    repeat (400) begin
      next_cycle();
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 99) < 60) push_rand(c, sparse_mask());
      fix = BR_MASK_W'(1) << $urandom_range(0, BR_MASK_W - 1);
      rec = ($urandom_range(0, 99) < 8);
      pc  = ($urandom_range(0, 99) < 12);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
